// File: rtl/regfile_wb_arbiter_pkg.sv
// Package: regfile_wb_arbiter_pkg
// Purpose : Shared register-file geometry for the writeback arbiter slice.
//           Holds the default register count, data width and index width,
//           plus the index of the hard-wired zero register.
// Contents: REG_COUNT, REG_W, REG_IDX_W, REG_ZERO localparams and
//           is_zero_reg() helper.
package regfile_wb_arbiter_pkg;

  localparam int REG_COUNT = 32;
  localparam int REG_W     = 32;
  localparam int REG_IDX_W = $clog2(REG_COUNT);
  localparam int REG_ZERO  = 0;

  // Writes to the zero register are architecturally discarded.
  function automatic logic is_zero_reg(input logic [REG_IDX_W-1:0] idx);
    return idx == REG_IDX_W'(REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Module : rr_arbiter
// Purpose: Combinational round-robin arbiter. Priority starts at the source
//          after ptr (wrapping modulo N); the first valid request wins.
// Ports  : req         in   N       request vector
//          ptr         in   IDX_W   index of the most recently granted source
//          grant       out  N       one-hot grant, all zero if no request
//          grant_idx   out  IDX_W   binary index of the granted source
//          grant_valid out  1       some request was granted
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  int idx;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Module : regfile_wb_arbiter
// Purpose: Shares the single register-file write port among NUM_REQ
//          writeback sources with a round-robin grant, registers the winning
//          write onto wr_en/wr_reg/wr_data, and keeps a pending-write
//          scoreboard that decode reserves at issue and queries via busy_a/b.
// Ports  : clk, aresetn (async, active low)
//          req_valid/req_reg/req_data in, req_ready out (one-hot grant)
//          wr_en/wr_reg/wr_data out (registered write port)
//          rsv_en/rsv_reg in (scoreboard reservation)
//          rd_reg_a/rd_reg_b in, busy_a/busy_b out (combinational)
//          fwd_a/fwd_b, fwd_data_a/fwd_data_b out (only with bypass)
// Config : define REGFILE_ARB_BYPASS_EN to forward the write being performed
//          this cycle to decode and suppress the matching busy.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int P_REG_COUNT = REG_COUNT,
  parameter int P_REG_W     = REG_W,
  parameter int P_REG_IDX_W = $clog2(P_REG_COUNT)
) (
  input  logic                         clk,
  input  logic                         aresetn,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*P_REG_IDX_W-1:0] req_reg,
  input  logic [NUM_REQ*P_REG_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         wr_en,
  output logic [P_REG_IDX_W-1:0]       wr_reg,
  output logic [P_REG_W-1:0]           wr_data,
  input  logic                         rsv_en,
  input  logic [P_REG_IDX_W-1:0]       rsv_reg,
  input  logic [P_REG_IDX_W-1:0]       rd_reg_a,
  input  logic [P_REG_IDX_W-1:0]       rd_reg_b,
`ifdef REGFILE_ARB_BYPASS_EN
  output logic                         fwd_a,
  output logic                         fwd_b,
  output logic [P_REG_W-1:0]           fwd_data_a,
  output logic [P_REG_W-1:0]           fwd_data_b,
`endif
  output logic                         busy_a,
  output logic                         busy_b
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic                   wr_en_q, wr_en_d;
  logic [P_REG_IDX_W-1:0] wr_reg_q, wr_reg_d;
  logic [P_REG_W-1:0]     wr_data_q, wr_data_d;
  logic [P_REG_COUNT-1:0] sb_q, sb_d;

  logic [PTR_W-1:0]       grant_idx;
  logic                   grant_valid;
  logic [P_REG_IDX_W-1:0] sel_reg;
  logic [P_REG_W-1:0]     sel_data;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(PTR_W)) u_rr (
    .req         (req_valid),
    .ptr         (ptr_q),
    .grant       (req_ready),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign sel_reg  = req_reg[grant_idx*P_REG_IDX_W +: P_REG_IDX_W];
  assign sel_data = req_data[grant_idx*P_REG_W +: P_REG_W];

  always_comb begin
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    if (grant_valid) begin
      ptr_d     = grant_idx;
      // A grant to the zero register still consumes the slot, but no write.
      wr_en_d   = !is_zero_reg(sel_reg);
      wr_reg_d  = sel_reg;
      wr_data_d = sel_data;
    end
  end

  // Clear is applied before set so a same-edge reservation (new producer)
  // keeps the bit.
  always_comb begin
    sb_d = sb_q;
    if (wr_en_q) sb_d[wr_reg_q] = 1'b0;
    if (rsv_en && !is_zero_reg(rsv_reg)) sb_d[rsv_reg] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ptr_q     <= PTR_W'(NUM_REQ - 1);
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
      sb_q      <= '0;
    end else begin
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
      sb_q      <= sb_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_reg  = wr_reg_q;
  assign wr_data = wr_data_q;

`ifdef REGFILE_ARB_BYPASS_EN
  assign fwd_a      = wr_en_q && (wr_reg_q == rd_reg_a) && !is_zero_reg(rd_reg_a);
  assign fwd_b      = wr_en_q && (wr_reg_q == rd_reg_b) && !is_zero_reg(rd_reg_b);
  assign fwd_data_a = wr_data_q;
  assign fwd_data_b = wr_data_q;
  assign busy_a     = sb_q[rd_reg_a] && !fwd_a;
  assign busy_b     = sb_q[rd_reg_b] && !fwd_b;
`else
  // Bit 0 is never set, so the zero register reads as not busy.
  assign busy_a = sb_q[rd_reg_a];
  assign busy_b = sb_q[rd_reg_b];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: table-driven arbitration vectors plus
// directed sequences for scoreboard, zero-register, reset and bypass cases.
module tb_regfile_wb_arbiter;

  localparam int NR = 3;
  localparam int IW = 5;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             aresetn;
  logic [NR-1:0]    req_valid;
  logic [NR*IW-1:0] req_reg;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             wr_en;
  logic [IW-1:0]    wr_reg;
  logic [DW-1:0]    wr_data;
  logic             rsv_en;
  logic [IW-1:0]    rsv_reg;
  logic [IW-1:0]    rd_reg_a, rd_reg_b;
  logic             busy_a, busy_b;
`ifdef REGFILE_ARB_BYPASS_EN
  logic             fwd_a, fwd_b;
  logic [DW-1:0]    fwd_data_a, fwd_data_b;
`endif

  regfile_wb_arbiter #(.NUM_REQ(NR)) dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .req_valid  (req_valid),
    .req_reg    (req_reg),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .wr_en      (wr_en),
    .wr_reg     (wr_reg),
    .wr_data    (wr_data),
    .rsv_en     (rsv_en),
    .rsv_reg    (rsv_reg),
    .rd_reg_a   (rd_reg_a),
    .rd_reg_b   (rd_reg_b),
`ifdef REGFILE_ARB_BYPASS_EN
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .fwd_data_a (fwd_data_a),
    .fwd_data_b (fwd_data_b),
`endif
    .busy_a     (busy_a),
    .busy_b     (busy_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [IW-1:0] r, input logic [DW-1:0] d);
    req_reg[i*IW +: IW]  = r;
    req_data[i*DW +: DW] = d;
  endtask

  typedef struct {
    logic [NR-1:0] valid;
    logic [NR-1:0] exp_ready;
    logic          exp_wr_en;
    logic [IW-1:0] exp_wr_reg;
    logic [DW-1:0] exp_wr_data;
  } vec_t;

  vec_t vecs[10];
  logic any_busy;

  initial begin
    // Sources 0/1/2 write regs 1/2/3 with data 0x100/0x101/0x102.
    vecs[0] = '{3'b111, 3'b001, 1'b0, 5'd0, 32'h0};
    vecs[1] = '{3'b111, 3'b010, 1'b1, 5'd1, 32'h100};
    vecs[2] = '{3'b111, 3'b100, 1'b1, 5'd2, 32'h101};
    vecs[3] = '{3'b111, 3'b001, 1'b1, 5'd3, 32'h102};
    vecs[4] = '{3'b000, 3'b000, 1'b1, 5'd1, 32'h100};
    vecs[5] = '{3'b110, 3'b010, 1'b0, 5'd1, 32'h100};
    vecs[6] = '{3'b101, 3'b100, 1'b1, 5'd2, 32'h101};
    vecs[7] = '{3'b001, 3'b001, 1'b1, 5'd3, 32'h102};
    vecs[8] = '{3'b000, 3'b000, 1'b1, 5'd1, 32'h100};
    vecs[9] = '{3'b000, 3'b000, 1'b0, 5'd1, 32'h100};

    aresetn   = 1'b0;
    req_valid = '0;
    req_reg   = '0;
    req_data  = '0;
    rsv_en    = 1'b0;
    rsv_reg   = '0;
    rd_reg_a  = '0;
    rd_reg_b  = '0;
    repeat (2) tick();
    aresetn = 1'b1;
    tick();

    // Reset state
    check("reset_wr_en", wr_en, 0);
    check("reset_wr_reg", wr_reg, 0);
    check("reset_wr_data", wr_data, 0);
    check("reset_ready", req_ready, 0);
    any_busy = 1'b0;
    for (int r = 0; r < 32; r++) begin
      rd_reg_a = IW'(r);
      rd_reg_b = IW'(31 - r);
      #1;
      any_busy = any_busy | busy_a | busy_b;
    end
    check("reset_busy_any", any_busy, 0);

    // Round-robin table
    for (int i = 0; i < NR; i++) set_src(i, IW'(i + 1), DW'(32'h100 + i));
    for (int v = 0; v < 10; v++) begin
      req_valid = vecs[v].valid;
      #1;
      check($sformatf("rr%0d_ready", v), req_ready, vecs[v].exp_ready);
      check($sformatf("rr%0d_wr_en", v), wr_en, vecs[v].exp_wr_en);
      check($sformatf("rr%0d_wr_reg", v), wr_reg, vecs[v].exp_wr_reg);
      check($sformatf("rr%0d_wr_data", v), wr_data, vecs[v].exp_wr_data);
      tick();
    end
    req_valid = '0;

    // Reserve reg 5, source 1 writes 0xDEAD to it
    rsv_en = 1'b1; rsv_reg = 5'd5; rd_reg_a = 5'd5; rd_reg_b = 5'd0;
    tick();
    rsv_en = 1'b0;
    #1;
    check("sb5_busy_after_rsv", busy_a, 1);
    check("sb5_zero_not_busy", busy_b, 0);
    set_src(1, 5'd5, 32'hDEAD);
    req_valid = 3'b010;
    #1;
    check("sb5_ready", req_ready, 3'b010);
    tick();
    req_valid = '0;
    #1;
    check("sb5_wr_en", wr_en, 1);
    check("sb5_wr_reg", wr_reg, 5);
    check("sb5_wr_data", wr_data, 32'hDEAD);
`ifdef REGFILE_ARB_BYPASS_EN
    check("sb5_busy_during_wr", busy_a, 0);
`else
    check("sb5_busy_during_wr", busy_a, 1);
`endif
    tick();
    check("sb5_wr_en_drop", wr_en, 0);
    check("sb5_busy_cleared", busy_a, 0);

    // Reserve reg 7 on the same edge that a write to reg 7 clears it
    set_src(2, 5'd7, 32'h77);
    req_valid = 3'b100;
    tick();
    req_valid = '0;
    rsv_en = 1'b1; rsv_reg = 5'd7; rd_reg_b = 5'd7;
    #1;
    check("rsv7_wr_en", wr_en, 1);
    check("rsv7_wr_reg", wr_reg, 7);
    tick();
    rsv_en = 1'b0;
    #1;
    check("rsv7_busy_kept", busy_b, 1);

    // Source 0 writes reg 0: granted but no write, zero never busy
    set_src(0, 5'd0, 32'hFFFF);
    req_valid = 3'b001;
    rd_reg_a  = 5'd0;
    #1;
    check("zero_ready", req_ready, 3'b001);
    tick();
    req_valid = '0;
    #1;
    check("zero_wr_en", wr_en, 0);
    check("zero_busy", busy_a, 0);
    check("rsv7_still_busy", busy_b, 1);

    // Async reset while a write is in flight and reg 4 is reserved
    rsv_en = 1'b1; rsv_reg = 5'd4;
    set_src(1, 5'd6, 32'h66);
    req_valid = 3'b010;
    tick();
    rsv_en = 1'b0; req_valid = '0; rd_reg_a = 5'd4;
    #1;
    check("rst_pre_wr_en", wr_en, 1);
    check("rst_pre_busy4", busy_a, 1);
    #2;
    aresetn = 1'b0;
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_busy4", busy_a, 0);
    check("rst_busy7", busy_b, 0);
    #1;
    aresetn = 1'b1;
    req_valid = 3'b111;
    #1;
    check("rst_first_grant", req_ready, 3'b001);
    tick();
    req_valid = '0;

`ifdef REGFILE_ARB_BYPASS_EN
    // Forward the write in progress to decode
    rsv_en = 1'b1; rsv_reg = 5'd9;
    tick();
    rsv_en = 1'b0;
    set_src(0, 5'd9, 32'h1234);
    req_valid = 3'b001;
    rd_reg_a = 5'd9; rd_reg_b = 5'd3;
    tick();
    req_valid = '0;
    #1;
    check("byp_fwd_a", fwd_a, 1);
    check("byp_fwd_data_a", fwd_data_a, 32'h1234);
    check("byp_busy_a", busy_a, 0);
    check("byp_fwd_b", fwd_b, 0);
`endif

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
